// File: rtl/spart_pkg.sv
// Shared definitions for the SPART command endpoint: timing defaults, command
// encoding and the state enums used by the UART and the command FSM.
package spart_pkg;

    localparam int CLK_FREQ_DEF = 100_000_000;
    localparam int BAUD_DEF     = 38_400;

    localparam int       OPC_BIT  = 0;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SEND_HI, C_SEND_LO, C_SEND_ACK} cmd_state_t;

    function automatic int baud_divisor(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/spart_uart.sv
// 8N1 LSB-first UART: synchronised receiver with mid-bit sampling and a
// transmitter that can chain a new byte straight out of its stop bit.
module spart_uart
    import spart_pkg::*;
#(
    parameter int DIVISOR = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready
);

    localparam int             CW       = $clog2(DIVISOR + 1);
    localparam logic [CW-1:0]  BIT_END  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0]  HALF_END = CW'(DIVISOR / 2 - 1);

    rx_state_t     rx_state, rx_next;
    logic [1:0]    rx_sync;
    logic          rx_prev;
    logic          rx_s;
    logic          rx_fall;
    logic          rx_tick;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_END) : (rx_cnt == BIT_END);
    assign rx_data = rx_shift;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_sync  <= {rx_sync[0], rxd};
            rx_prev  <= rx_s;
            rx_cnt   <= (rx_state != rx_next || rx_tick || rx_state == RX_IDLE) ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            rx_valid <= (rx_state == RX_STOP) && rx_tick && rx_s;
            rx_error <= (rx_state == RX_STOP) && rx_tick && !rx_s;
        end
    end

    tx_state_t     tx_state, tx_next;
    logic          tx_tick;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    assign tx_tick  = (tx_cnt == BIT_END);
    // Accepting during the last stop-bit clock gives back-to-back frames.
    assign tx_ready = (tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_start) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = tx_start ? TX_START : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state != tx_next || tx_tick || tx_state == TX_IDLE) ? '0 : tx_cnt + 1'b1;
            if (tx_ready && tx_start) begin
                tx_shift <= tx_data;
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= {1'b1, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

endmodule

// File: rtl/spart_top_level.sv
// SPART command endpoint: 4-byte WRITE/READ commands over serial into a 256x16
// register file. Define WRITE_ACK_EN to answer each WRITE with an ACK byte.
module spart_top_level
    import spart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic txd
);

    localparam int DIVISOR = baud_divisor(CLK_FREQ, BAUD);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready;

    spart_uart #(.DIVISOR(DIVISOR)) u_uart (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .txd      (txd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    // Bytes ripple data -> addr -> opcode, so after B3 the fields hold B0..B3.
    logic [1:0]  byte_cnt;
    logic        cmd_pulse;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            cmd_pulse <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
        end else begin
            cmd_pulse <= rx_valid && (byte_cnt == 2'd3);
            if (rx_error) begin
                byte_cnt <= '0;
            end else if (rx_valid) begin
                byte_cnt  <= byte_cnt + 2'd1;
                cmd_data  <= {cmd_data[7:0], rx_data};
                cmd_addr  <= cmd_data[15:8];
                cmd_write <= cmd_addr[OPC_BIT];
            end
        end
    end

    logic [15:0] mem [256];

    // NOTE: the register file must read back zero after reset, so it is built from resettable flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (cmd_pulse && cmd_write) begin
            mem[cmd_addr] <= cmd_data;
        end
    end

    cmd_state_t  cmd_state, cmd_next;
    logic [15:0] reply;

    always_comb begin
        cmd_next = cmd_state;
        tx_start = 1'b0;
        tx_data  = reply[15:8];
        case (cmd_state)
            C_IDLE: begin
                if (cmd_pulse) begin
                    if (!cmd_write) cmd_next = C_SEND_HI;
`ifdef WRITE_ACK_EN
                    else cmd_next = C_SEND_ACK;
`endif
                end
            end
            C_SEND_HI: begin
                tx_start = 1'b1;
                if (tx_ready) cmd_next = C_SEND_LO;
            end
            C_SEND_LO: begin
                tx_start = 1'b1;
                tx_data  = reply[7:0];
                if (tx_ready) cmd_next = C_IDLE;
            end
            C_SEND_ACK: begin
                tx_start = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) cmd_next = C_IDLE;
            end
            default: cmd_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_state <= C_IDLE;
            reply     <= '0;
        end else begin
            cmd_state <= cmd_next;
            if (cmd_pulse && cmd_state == C_IDLE) reply <= mem[cmd_addr];
        end
    end

endmodule

// File: tb/tb_spart_top_level.sv
// Directed bench for spart_top_level at a reduced bit period (16 clocks/bit).
// Build with WRITE_ACK_EN defined to expect the ACK byte after each WRITE.
module tb_spart_top_level;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic txd;

    int checks = 0;
    int errors = 0;

    spart_top_level #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .txd (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic recv_byte(input string tag, input int budget, output logic [7:0] b);
        int n = 0;
        b = 8'hxx;
        while (txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) begin
            check({tag, "_start_timeout"}, 16'(txd), 16'h0);
            return;
        end
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        check({tag, "_stop"}, 16'(txd), 16'h1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check(tag, 16'(lows), 16'h0);
    endtask

    task automatic do_write(input string tag, input logic [7:0] b0, addr, dhi, dlo);
        logic [7:0] ack;
        fork
            send_cmd(b0, addr, dhi, dlo);
`ifdef WRITE_ACK_EN
            begin
                recv_byte({tag, "_ack"}, 2000, ack);
                check({tag, "_ack"}, 16'(ack), 16'h0006);
            end
`else
            begin
                ack = 8'h00;
                expect_quiet({tag, "_quiet"}, 4 * 11 * DIV + 20 * DIV);
            end
`endif
        join
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr, fill, input logic [15:0] exp);
        logic [7:0] hi, lo;
        fork
            send_cmd(8'h54, addr, fill, fill);
            begin
                recv_byte({tag, "_hi"}, 2000, hi);
                check({tag, "_hi"}, 16'(hi), 16'(exp[15:8]));
                recv_byte({tag, "_lo"}, 12, lo);
                check({tag, "_lo"}, 16'(lo), 16'(exp[7:0]));
            end
        join
        repeat (DIV) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (5) @(negedge clk);
        check("reset_txd", 16'(txd), 16'h1);
        rst = 1'b1;
        expect_quiet("idle_after_reset", 10 * DIV);

        do_write("wr_aa", 8'h55, 8'hAA, 8'hAA, 8'hAA);
        do_read("rd_aa", 8'hAA, 8'h00, 16'hAAAA);
        do_read("rd_ab_unwritten", 8'hAB, 8'hAB, 16'h0000);

        do_write("wr_ff", 8'hFD, 8'hFF, 8'hC3, 8'h5A);
        do_read("rd_ff", 8'hFF, 8'h00, 16'hC35A);

        // A stray byte followed by a framing error must leave the assembler at byte 0.
        send_byte(8'h54, 1'b1);
        send_byte(8'hA5, 1'b0);
        do_write("wr_12", 8'h55, 8'h12, 8'hBE, 8'hEF);
        do_read("rd_12", 8'h12, 8'h00, 16'hBEEF);

        fork
            send_cmd(8'h54, 8'hAA, 8'h00, 8'h00);
            begin
                n = 0;
                while (txd !== 1'b0 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                check("mid_reply_started", 16'(txd), 16'h0);
                repeat (40) @(negedge clk);
                rst = 1'b0;
                #1;
                check("reset_mid_reply_txd", 16'(txd), 16'h1);
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2 * DIV) @(negedge clk);

        do_read("rd_aa_after_reset", 8'hAA, 8'h00, 16'h0000);
        do_write("wr_34", 8'h01, 8'h34, 8'h12, 8'h34);
        do_read("rd_34", 8'h34, 8'h00, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
